// File: rtl/npc_mem_responder.sv
// Data-memory responder: one request at a time, fixed access latency,
// word RAM behind a valid/ready request and response channel.
//
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready, req_wen, req_addr, req_wdata, req_wmask
//   resp_valid/resp_ready, resp_rdata, resp_err
module npc_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;
  localparam logic [3:0] CNT_INIT =
    (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam bit ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_wen;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wmask;

  logic [31:0] mem [DEPTH_WORDS];

  logic          op_wen;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic [3:0]    op_wmask;
  logic [31:0]   off;
  logic [AW-1:0] op_idx;
  logic          op_err;
  logic          enter_resp;
  logic          do_write;
  logic [31:0]   rd_word;

  // With zero latency the commit happens on the accept edge itself,
  // so the live request fields are used instead of the latched copy.
  always_comb begin
    op_wen   = lat_wen;
    op_addr  = lat_addr;
    op_wdata = lat_wdata;
    op_wmask = lat_wmask;
    if (state == IDLE) begin
      op_wen   = req_wen;
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_wmask = req_wmask;
    end
  end

  // Addresses below the base wrap to a huge offset and fail the range test.
  assign off    = op_addr - ADDR_BASE;
  assign op_idx = off[AW+1:2];
  assign op_err = (op_addr[1:0] != 2'b00) || (off >= SPAN);

  assign enter_resp = reset && (
    ((state == IDLE) && req_valid && ZERO_LAT) ||
    ((state == WAIT) && (cnt == 4'd0)));

  assign do_write = enter_resp && op_wen && !op_err;

  assign rd_word = (!op_wen && !op_err) ? mem[op_idx] : 32'd0;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (op_wmask[i]) begin
          mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      lat_wen    <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_wmask  <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            lat_wen   <= req_wen;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wmask <= req_wmask;
            req_ready <= 1'b0;
            if (ZERO_LAT) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= rd_word;
              resp_err   <= op_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= rd_word;
            resp_err   <= op_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_mem_responder.sv
// Bench for npc_mem_responder: three instances (latency 2, 0, 3)
// driven from a shared vector table plus hand-written corner sequences.
module tb_npc_mem_responder;

  localparam int NI = 3;
  localparam int LATS [NI] = '{2, 0, 3};

  logic        clk;
  logic        rst_n      [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_wen    [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic [3:0]  req_wmask  [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    npc_mem_responder #(
      .ADDR_BASE  (32'h8000_0000),
      .DEPTH_WORDS(1024),
      .LATENCY    (LATS[g])
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_wen   (req_wen[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_wmask (req_wmask[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  vec_t tbl [20];
  exp_t sbq [$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_reset(input int d, input string nm);
    chk({nm, " req_ready"}, 32'(req_ready[d]), 32'd1);
    chk({nm, " resp_valid"}, 32'(resp_valid[d]), 32'd0);
    chk({nm, " resp_rdata"}, resp_rdata[d], 32'd0);
    chk({nm, " resp_err"}, 32'(resp_err[d]), 32'd0);
  endtask

  task automatic xact(input int d, input logic wen,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mask, input logic [31:0] er,
                      input logic ee, input string nm);
    exp_t e;
    int   lat;
    bit   got;
    e.rdata = er;
    e.err   = ee;
    e.lat   = LATS[d];
    sbq.push_back(e);
    @(negedge clk);
    resp_ready[d] = 1'b1;
    req_valid[d]  = 1'b1;
    req_wen[d]    = wen;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_wmask[d]  = mask;
    chk({nm, " req_ready"}, 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (resp_valid[d]) got = 1'b1;
      else lat++;
    end
    e = sbq.pop_front();
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=none required=resp_valid", nm);
    end else begin
      chk({nm, " latency"}, 32'(lat), 32'(e.lat));
      chk({nm, " rdata"}, resp_rdata[d], e.rdata);
      chk({nm, " err"}, 32'(resp_err[d]), 32'(e.err));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 32'h8000_0010, 32'h1122_3344, 4'hF, 32'h0, 0};
    tbl[1]  = '{0, 32'h8000_0010, 32'h0, 4'h0, 32'h1122_3344, 0};
    tbl[2]  = '{1, 32'h8000_0020, 32'hAABB_CCDD, 4'hF, 32'h0, 0};
    tbl[3]  = '{1, 32'h8000_0020, 32'h0000_0099, 4'h1, 32'h0, 0};
    tbl[4]  = '{0, 32'h8000_0020, 32'h0, 4'h0, 32'hAABB_CC99, 0};
    tbl[5]  = '{1, 32'h8000_0020, 32'h1234_0000, 4'hC, 32'h0, 0};
    tbl[6]  = '{0, 32'h8000_0020, 32'h0, 4'h0, 32'h1234_CC99, 0};
    tbl[7]  = '{1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0, 0};
    tbl[8]  = '{0, 32'h8000_0020, 32'h0, 4'h0, 32'h1234_CC99, 0};
    tbl[9]  = '{1, 32'h8000_0000, 32'h0102_0304, 4'hF, 32'h0, 0};
    tbl[10] = '{1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 0};
    tbl[11] = '{0, 32'h8000_0002, 32'h0, 4'h0, 32'h0, 1};
    tbl[12] = '{0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1};
    tbl[13] = '{0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 1};
    tbl[14] = '{1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1};
    tbl[15] = '{1, 32'h8000_0012, 32'hEEEE_EEEE, 4'hF, 32'h0, 1};
    tbl[16] = '{1, 32'h7FFF_FFFC, 32'h5555_5555, 4'hF, 32'h0, 1};
    tbl[17] = '{0, 32'h8000_0000, 32'h0, 4'h0, 32'h0102_0304, 0};
    tbl[18] = '{0, 32'h8000_0010, 32'h0, 4'h0, 32'h1122_3344, 0};
    tbl[19] = '{0, 32'h8000_0FFC, 32'h0, 4'h0, 32'hCAFE_F00D, 0};

    for (int d = 0; d < NI; d++) begin
      rst_n[d]      = 1'b0;
      req_valid[d]  = 1'b0;
      req_wen[d]    = 1'b0;
      req_addr[d]   = 32'h0;
      req_wdata[d]  = 32'h0;
      req_wmask[d]  = 4'h0;
      resp_ready[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < NI; d++) chk_reset(d, $sformatf("reset%0d", d));
    for (int d = 0; d < NI; d++) rst_n[d] = 1'b1;

    for (int d = 0; d < NI; d++) begin
      for (int i = 0; i < 20; i++) begin
        xact(d, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].mask,
             tbl[i].rdata, tbl[i].err, $sformatf("vec%0d_d%0d", i, d));
      end
    end

    // backpressure on the latency-2 instance
    begin
      bit got = 1'b0;
      @(negedge clk);
      resp_ready[0] = 1'b0;
      req_valid[0]  = 1'b1;
      req_wen[0]    = 1'b0;
      req_addr[0]   = 32'h8000_0010;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (resp_valid[0]) got = 1'b1;
      end
      chk("bp resp_seen", 32'(got), 32'd1);
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("bp%0d valid", k), 32'(resp_valid[0]), 32'd1);
        chk($sformatf("bp%0d rdata", k), resp_rdata[0], 32'h1122_3344);
        chk($sformatf("bp%0d err", k), 32'(resp_err[0]), 32'd0);
        chk($sformatf("bp%0d req_ready", k), 32'(req_ready[0]), 32'd0);
        @(negedge clk);
      end
      resp_ready[0] = 1'b1;
      @(negedge clk);
      chk("bp release valid", 32'(resp_valid[0]), 32'd0);
      chk("bp release req_ready", 32'(req_ready[0]), 32'd1);
    end

    // latency-0 back-to-back loads
    @(negedge clk);
    resp_ready[1] = 1'b1;
    req_valid[1]  = 1'b1;
    req_wen[1]    = 1'b0;
    req_addr[1]   = 32'h8000_0010;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b%0d req_ready", k), 32'(req_ready[1]),
          32'(k % 2 == 0));
      chk($sformatf("b2b%0d resp_valid", k), 32'(resp_valid[1]),
          32'(k % 2 == 1));
      if (k % 2 == 1)
        chk($sformatf("b2b%0d rdata", k), resp_rdata[1], 32'h1122_3344);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;

    // reset during WAIT on the latency-3 instance
    xact(2, 1'b1, 32'h8000_0030, 32'h0, 4'hF, 32'h0, 1'b0, "clr30");
    @(negedge clk);
    resp_ready[2] = 1'b1;
    req_valid[2]  = 1'b1;
    req_wen[2]    = 1'b1;
    req_addr[2]   = 32'h8000_0030;
    req_wdata[2]  = 32'h5A5A_5A5A;
    req_wmask[2]  = 4'hF;
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    chk("wait req_ready", 32'(req_ready[2]), 32'd0);
    rst_n[2] = 1'b0;
    #1 chk_reset(2, "rst_wait");
    @(negedge clk);
    rst_n[2] = 1'b1;
    xact(2, 1'b0, 32'h8000_0030, 32'h0, 4'h0, 32'h0, 1'b0, "after_rst_wait");

    // reset during RESP: store already committed
    begin
      bit got = 1'b0;
      @(negedge clk);
      resp_ready[2] = 1'b0;
      req_valid[2]  = 1'b1;
      req_wen[2]    = 1'b1;
      req_addr[2]   = 32'h8000_0030;
      req_wdata[2]  = 32'h5A5A_5A5A;
      req_wmask[2]  = 4'hF;
      @(posedge clk);
      #1 req_valid[2] = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (resp_valid[2]) got = 1'b1;
      end
      chk("resp_rst seen", 32'(got), 32'd1);
      rst_n[2] = 1'b0;
      #1 chk_reset(2, "rst_resp");
      @(negedge clk);
      rst_n[2] = 1'b1;
      resp_ready[2] = 1'b1;
    end
    xact(2, 1'b0, 32'h8000_0030, 32'h0, 4'h0, 32'h5A5A_5A5A, 1'b0,
         "after_rst_resp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/npc_mem_responder.md
Name: npc_mem_responder

Overview:
- Memory-side responder (slave) for the core's data-memory load/store requests.
- Accepts one request at a time over a valid/ready handshake and holds it in a small internal word-addressed RAM.
- Applies a configurable access latency, then returns read data or a write acknowledgement over a valid/ready response channel.
- Replaces the zero-latency behavioural memory path so the core's multi-cycle memory interface can be exercised in RTL simulation.

Parameters:
- ADDR_BASE, 32'h80000000: byte address mapped to RAM word 0.
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 4.
- LATENCY, 2: wait cycles between request accept and response valid; range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_wen  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, little-endian lanes.
- req_wmask  input  4  byte-lane write enables; bit i controls wdata[8i+7:8i].
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  load data (full aligned word); 0 for stores and errors.
- resp_err  output  1  address out of range or misaligned.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - RAM contents are not reset.
- FSM states:
  - IDLE: req_ready=1. When req_valid=1 at a rising edge, the request is accepted. Addr, wen, wdata and wmask are latched into internal registers. Next state is WAIT if LATENCY>0, else RESP.
  - WAIT: req_ready=0. The counter loads LATENCY-1 on accept and decrements each cycle. When the counter reaches 0, the next state is RESP.
  - RESP: req_ready=0, resp_valid=1. On resp_ready=1 at a rising edge, the next state is IDLE and resp_valid drops. resp_rdata and resp_err hold stable while resp_valid=1 and resp_ready=0.
- Timing:
  - A request accepted at edge T makes resp_valid=1 after edge T+LATENCY.
  - LATENCY=0 gives response valid in the cycle immediately after accept.
  - Minimum occupancy is LATENCY+2 cycles per transaction.
  - A new request is never accepted in the same cycle as a response handshake.
- Address decode: off = req_addr - ADDR_BASE (32-bit modular); idx = off[31:2].
  - err = (req_addr[1:0]!=0) or (off >= DEPTH_WORDS*4).
  - Addresses below ADDR_BASE wrap to a large off and give err=1.
- Commit point: the RAM write and read sample happen at the edge that enters RESP.
  - Store, no err: for each i with wmask[i]=1, RAM[idx] byte i = wdata byte i. Other bytes are unchanged. resp_rdata=0.
  - Store with wmask=0: no change, err=0.
  - Load, no err: resp_rdata = RAM[idx] as stored, with no byte swapping.
  - err=1: no RAM change, resp_rdata=0, resp_err=1.
- Ordering: only one transaction is outstanding, so a load after a store to the same address always returns the stored bytes.
- Reset mid-operation: an assertion during WAIT discards the pending request; a store still in WAIT is not committed. An assertion during RESP drops the response, and the store is already committed. Back to IDLE in either case.
- req_* inputs are ignored outside IDLE. The responder tolerates req_valid deasserting without acceptance.

Test Plan:
- LATENCY=2. Store addr 80000010, wdata 11223344, wmask F, resp_ready=1. Expect resp_valid after accept edge +2 with resp_err=0 and resp_rdata=0. Then load 80000010 → resp_rdata=11223344.
- Byte masks: RAM[80000020]=AABBCCDD. Store wdata 00000099 with wmask 1, then a load returns AABBCC99. Store 12340000 with wmask C, then a load returns 1234CC99. Store with wmask 0: value unchanged, err=0.
- Errors, each must leave RAM untouched:
  - Load 80000002 → resp_err=1, rdata=0.
  - Load 7FFFFFFC → resp_err=1.
  - Load 80001000 (DEPTH 1024) → resp_err=1.
  - Store 80001000 → resp_err=1.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid. resp_valid, resp_rdata and resp_err must stay stable and req_ready must stay 0. Release resp_ready; req_ready returns to 1 the next cycle.
- LATENCY=0 build: requests back-to-back with resp_ready=1. Response valid the cycle after accept; accepts occur every 2 cycles.
- Reset mid-op, LATENCY=3:
  - Issue a store to 80000030, whose prior value is 0. Assert reset during WAIT. All outputs go to their reset values asynchronously. A subsequent load returns 0.
  - Repeat with reset asserted during RESP. A subsequent load returns the stored value.
